// File: rtl/tone_pkg.sv
// Shared definitions for the note tone generator.
//   NOTE_DIV   : base half-period divider per note-in-octave (0..11)
//   NOTE_MAX   : highest legal note index
//   state_e    : controller states
//   oct_reload : octave down-counter reload value (255 >> octave)
package tone_pkg;

  localparam logic [3:0] NOTE_MAX = 4'd11;

  localparam logic [8:0] NOTE_DIV [12] = '{
    9'd511, 9'd482, 9'd455, 9'd430, 9'd405, 9'd383,
    9'd361, 9'd341, 9'd322, 9'd303, 9'd286, 9'd270
  };

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_e;

  function automatic logic [7:0] oct_reload(input logic [2:0] oct);
    return 8'(8'd255 >> oct);
  endfunction

endpackage

// File: rtl/note_tone_gen_if.sv
// Note request / tone output bundle between the note splitter, the tone
// generator and the speaker pad.
//   octave_in, note_in, note_valid, rest : request side (master drives)
//   speaker, active, note_ack            : generator status (slave drives)
interface note_tone_gen_if;
  logic [2:0] octave_in;
  logic [3:0] note_in;
  logic       note_valid;
  logic       rest;
  logic       speaker;
  logic       active;
  logic       note_ack;

  modport master (
    output octave_in, note_in, note_valid, rest,
    input  speaker, active, note_ack
  );

  modport slave (
    input  octave_in, note_in, note_valid, rest,
    output speaker, active, note_ack
  );
endinterface

// File: rtl/tone_div_lut.sv
// Combinational note -> base divider lookup.
//   note_i : note-in-octave; values above NOTE_MAX return 0
//   div_o  : half-period base divider
module tone_div_lut
  import tone_pkg::*;
#(
  parameter int NOTE_W = 9
) (
  input  logic [3:0]        note_i,
  output logic [NOTE_W-1:0] div_o
);

  always_comb begin
    div_o = '0;
    for (int i = 0; i < 12; i++) begin
      if (note_i == 4'(i)) div_o = NOTE_W'(NOTE_DIV[i]);
    end
  end

endmodule

// File: rtl/note_tone_gen.sv
// Square-wave tone generator for the board speaker.
//   clk, rst_n : system clock, async active-low reset
//   tone       : slave side of note_tone_gen_if (request in, speaker out)
//
// Half-period = (NOTE_DIV[note]+1) * (oct_reload(octave)+1) clk cycles. Note
// changes and rests only take effect at half-period boundaries so the speaker
// never emits a truncated pulse.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | silent, speaker=0; waits for a pending note with rest low
// PLAY  | counters running, speaker toggles at each half-period boundary
module note_tone_gen
  import tone_pkg::*;
#(
  parameter int NOTE_W  = 9,
  parameter int OCT_W   = 8,
  parameter int NUM_OCT = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  note_tone_gen_if.slave  tone
);

  state_e             state_q;
  logic [NOTE_W-1:0]  cnt_note_q;
  logic [OCT_W-1:0]   cnt_oct_q;
  logic [2:0]         cur_oct_q;
  logic [3:0]         cur_note_q;
  logic [2:0]         pend_oct_q;
  logic [3:0]         pend_note_q;
  logic               pend_flag_q;
  logic               speaker_q;
  logic               active_q;
  logic               note_ack_q;

  logic               boundary;
  logic               apply;
  logic               pend_legal;
  logic [3:0]         lut_note;
  logic [NOTE_W-1:0]  lut_div;

  assign boundary   = (state_q == PLAY) && (cnt_note_q == '0) && (cnt_oct_q == '0);
  // rest wins over a pending note at a boundary; the note stays pending and
  // is picked up from IDLE once rest drops.
  assign apply      = pend_flag_q && !tone.rest && ((state_q == IDLE) || boundary);
  assign pend_legal = (pend_note_q <= NOTE_MAX) && (32'(pend_oct_q) < NUM_OCT);

  // One lookup serves both loading a new note and reloading the current one.
  assign lut_note = apply ? pend_note_q : cur_note_q;

  tone_div_lut #(.NOTE_W(NOTE_W)) u_lut (
    .note_i (lut_note),
    .div_o  (lut_div)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_note_q  <= '0;
      cnt_oct_q   <= '0;
      cur_oct_q   <= '0;
      cur_note_q  <= '0;
      pend_oct_q  <= '0;
      pend_note_q <= '0;
      pend_flag_q <= 1'b0;
      speaker_q   <= 1'b0;
      active_q    <= 1'b0;
      note_ack_q  <= 1'b0;
    end else begin
      note_ack_q <= 1'b0;

      // A strobe on the apply edge refills the register, so it stays pending.
      if (tone.note_valid) begin
        pend_oct_q  <= tone.octave_in;
        pend_note_q <= tone.note_in;
        pend_flag_q <= 1'b1;
      end else if (apply) begin
        pend_flag_q <= 1'b0;
      end

      if (apply) begin
        note_ack_q <= 1'b1;
        if (pend_legal) begin
          cur_oct_q  <= pend_oct_q;
          cur_note_q <= pend_note_q;
          cnt_note_q <= lut_div;
          cnt_oct_q  <= OCT_W'(oct_reload(pend_oct_q));
          active_q   <= 1'b1;
          state_q    <= PLAY;
          speaker_q  <= (state_q == PLAY) ? ~speaker_q : 1'b0;
        end else begin
          cnt_note_q <= '0;
          cnt_oct_q  <= '0;
          active_q   <= 1'b0;
          speaker_q  <= 1'b0;
          state_q    <= IDLE;
        end
      end else if (state_q == PLAY) begin
        if (cnt_note_q != '0) begin
          cnt_note_q <= cnt_note_q - NOTE_W'(1);
        end else begin
          cnt_note_q <= lut_div;
          if (cnt_oct_q != '0) begin
            cnt_oct_q <= cnt_oct_q - OCT_W'(1);
          end else if (tone.rest) begin
            cnt_note_q <= '0;
            cnt_oct_q  <= '0;
            active_q   <= 1'b0;
            speaker_q  <= 1'b0;
            state_q    <= IDLE;
          end else begin
            cnt_oct_q <= OCT_W'(oct_reload(cur_oct_q));
            speaker_q <= ~speaker_q;
          end
        end
      end
    end
  end

  assign tone.speaker  = speaker_q;
  assign tone.active   = active_q;
  assign tone.note_ack = note_ack_q;

endmodule

// File: tb/tb_note_tone_gen.sv
module tb_note_tone_gen;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  note_tone_gen_if tif ();

  note_tone_gen #(.NOTE_W(9), .OCT_W(8), .NUM_OCT(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tone  (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] oct;
    logic [3:0] note;
    int         half;   // expected half-period in clk; 0 = illegal note
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    step(1);
  endtask

  // Drive one strobe; returns just after the capturing edge.
  task automatic strobe(input logic [2:0] o, input logic [3:0] n);
    tif.octave_in  = o;
    tif.note_in    = n;
    tif.note_valid = 1'b1;
    step(1);
    tif.note_valid = 1'b0;
  endtask

  // Count edges until speaker changes; n=-1 if the budget runs out.
  task automatic wait_toggle(input int budget, output int n, output int acks);
    logic prev;
    bit   done;
    prev = tif.speaker;
    n    = -1;
    acks = 0;
    done = 1'b0;
    for (int i = 1; i <= budget && !done; i++) begin
      @(posedge clk);
      #1;
      if (tif.note_ack) acks++;
      if (tif.speaker !== prev) begin
        n    = i;
        done = 1'b1;
      end
    end
  endtask

  initial begin
    int n;
    int acks;
    total = 0;
    bad   = 0;

    vecs[0] = '{oct: 3'd5, note: 4'd0,  half: 4096};
    vecs[1] = '{oct: 3'd5, note: 4'd11, half: 2168};
    vecs[2] = '{oct: 3'd5, note: 4'd6,  half: 2896};
    vecs[3] = '{oct: 3'd5, note: 4'd13, half: 0};
    vecs[4] = '{oct: 3'd6, note: 4'd0,  half: 0};
    vecs[5] = '{oct: 3'd7, note: 4'd5,  half: 0};

    rst_n          = 1'b0;
    tif.octave_in  = '0;
    tif.note_in    = '0;
    tif.note_valid = 1'b0;
    tif.rest       = 1'b0;

    step(2);
    chk("rst_speaker", int'(tif.speaker), 0);
    chk("rst_active", int'(tif.active), 0);
    chk("rst_ack", int'(tif.note_ack), 0);
    #3 rst_n = 1'b1;
    step(1);

    foreach (vecs[v]) begin
      do_reset();
      strobe(vecs[v].oct, vecs[v].note);
      chk($sformatf("v%0d_ack_early", v), int'(tif.note_ack), 0);
      step(1);
      chk($sformatf("v%0d_ack", v), int'(tif.note_ack), 1);
      chk($sformatf("v%0d_active", v), int'(tif.active), vecs[v].half != 0 ? 1 : 0);
      chk($sformatf("v%0d_spk0", v), int'(tif.speaker), 0);
      if (vecs[v].half != 0) begin
        wait_toggle(10000, n, acks);
        chk($sformatf("v%0d_half1", v), n, vecs[v].half);
        chk($sformatf("v%0d_acks", v), acks, 0);
        chk($sformatf("v%0d_spk1", v), int'(tif.speaker), 1);
        wait_toggle(10000, n, acks);
        chk($sformatf("v%0d_half2", v), n, vecs[v].half);
      end else begin
        wait_toggle(50, n, acks);
        chk($sformatf("v%0d_silent", v), n, -1);
        chk($sformatf("v%0d_idle_active", v), int'(tif.active), 0);
      end
    end

    // Octave 0 is far too slow to measure; it must sound but not toggle early.
    do_reset();
    strobe(3'd0, 4'd0);
    step(1);
    chk("oct0_ack", int'(tif.note_ack), 1);
    chk("oct0_active", int'(tif.active), 1);
    wait_toggle(5000, n, acks);
    chk("oct0_no_toggle", n, -1);

    // Note change mid half-period: current half completes, then new note.
    do_reset();
    strobe(3'd5, 4'd0);
    step(1);
    step(1000);
    strobe(3'd4, 4'd0);
    wait_toggle(5000, n, acks);
    chk("chg_half", n + 1001, 4096);
    chk("chg_one_ack", acks, 1);
    chk("chg_ack_at_edge", int'(tif.note_ack), 1);
    chk("chg_spk", int'(tif.speaker), 1);
    wait_toggle(10000, n, acks);
    chk("chg_new_half", n, 8192);
    chk("chg_no_ack", acks, 0);

    // Rest 1000 cycles into a high half-period.
    do_reset();
    strobe(3'd5, 4'd0);
    step(1);
    wait_toggle(5000, n, acks);
    chk("rest_first_half", n, 4096);
    step(1000);
    tif.rest = 1'b1;
    chk("rest_hold_spk", int'(tif.speaker), 1);
    wait_toggle(5000, n, acks);
    chk("rest_stop_at", n + 1000, 4096);
    chk("rest_spk", int'(tif.speaker), 0);
    chk("rest_active", int'(tif.active), 0);
    step(5);
    tif.rest = 1'b0;
    wait_toggle(3000, n, acks);
    chk("rest_stays_idle", n, -1);
    chk("rest_idle_active", int'(tif.active), 0);
    strobe(3'd5, 4'd0);
    step(1);
    chk("rest_restart_ack", int'(tif.note_ack), 1);
    chk("rest_restart_active", int'(tif.active), 1);

    // Illegal note arriving while playing stops the tone at the boundary.
    do_reset();
    strobe(3'd5, 4'd11);
    step(1);
    wait_toggle(5000, n, acks);
    chk("ill_first_half", n, 2168);
    strobe(3'd5, 4'd13);
    wait_toggle(5000, n, acks);
    chk("ill_stop_at", n + 1, 2168);
    chk("ill_ack", int'(tif.note_ack), 1);
    chk("ill_active", int'(tif.active), 0);
    chk("ill_spk", int'(tif.speaker), 0);

    // Async reset between edges mid-tone.
    do_reset();
    strobe(3'd5, 4'd0);
    step(1);
    wait_toggle(5000, n, acks);
    chk("ar_half", n, 4096);
    step(500);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_spk_now", int'(tif.speaker), 0);
    chk("ar_active_now", int'(tif.active), 0);
    chk("ar_cnt_note_now", int'(dut.cnt_note_q), 0);
    chk("ar_cnt_oct_now", int'(dut.cnt_oct_q), 0);
    #1 rst_n = 1'b1;
    step(1);
    wait_toggle(10000, n, acks);
    chk("ar_silent", n, -1);
    chk("ar_no_ack", acks, 0);
    chk("ar_active_after", int'(tif.active), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/note_tone_gen.md
Name: note_tone_gen

Overview:
- Audio tone generator that sits directly downstream of the divide-by-12 note splitter.
- Consumes an octave number (0..5) and a note-in-octave (0..11), and drives a square wave on a single speaker pin.
- Note changes are applied glitch-free, only at half-period boundaries.
- Feeds the board speaker/PWM pad directly.

Parameters:
- NOTE_W, 9: width of the note-period down-counter. The base divider table is defined for 9 bits.
- OCT_W, 8: width of the octave down-counter.
- NUM_OCT, 6: number of legal octaves (0..NUM_OCT-1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- octave_in  in  3  quotient from the note splitter
- note_in  in  4  remainder from the note splitter; legal range 0..11
- note_valid  in  1  single-cycle strobe; captures octave_in/note_in into the pending register
- rest  in  1  level input; 1 = silence request
- speaker  out  1  square-wave output
- active  out  1  1 while a legal note is sounding
- note_ack  out  1  1-cycle pulse when a pending note becomes the active note

Behaviour:
- Reset is one clock, asynchronous and active-low: rst_n low clears all state immediately, independent of clk.
- Reset values: speaker=0, active=0, note_ack=0, both counters=0, pending empty, state IDLE.
- Base divider LUT, indexed by note 0..11: 511, 482, 455, 430, 405, 383, 361, 341, 322, 303, 286, 270.
- Octave reload value: 255 >> octave, giving 255, 127, 63, 31, 15, 7 for octaves 0..5.
- Pending register: note_valid=1 loads {octave_in, note_in} and sets pending_flag. A later note_valid before it is applied overwrites it (last wins).
- State machine has two states, IDLE and PLAY.
- IDLE:
  - speaker held at 0.
  - If pending_flag=1 and rest=0: the pending note is applied on the next edge. Action: load cnt_note=LUT[note], load cnt_oct=reload[octave], clear pending_flag, pulse note_ack, set active=1, go to PLAY.
- PLAY, every cycle:
  - If cnt_note != 0: cnt_note decrements.
  - Else (cnt_note == 0): cnt_note reloads LUT[cur_note], and cnt_oct decrements, or reloads when it is 0.
  - When cnt_note==0 and cnt_oct==0, speaker toggles. This is the half-period boundary.
  - Half-period = (LUT+1)*(reload+1) clk cycles.
- At a half-period boundary in PLAY:
  - If pending_flag=1: the pending note is applied. Both counters load from the new note, note_ack pulses, and speaker still toggles.
  - If rest=1: next state is IDLE, active=0, and speaker is forced to 0 on that same edge.
- rest asserted mid-half-period: the tone finishes the current half-period, then stops. No truncated pulse is produced.
- Illegal note (note_in > 11 or octave_in >= NUM_OCT):
  - On application it is treated as a rest: go to IDLE or stay there, active=0, note_ack still pulses.
  - It is never loaded into the counters.
- Simultaneous note_valid and application on the same edge: the new input wins the pending register, and the previously pending value is applied.
- Reset asserted mid-tone: everything clears immediately. After release, nothing sounds until a new note_valid arrives.
- No combinational path from inputs to speaker. speaker is a flop output.

Decomposition:
- Package tone_pkg holds:
  - the 12-entry NOTE_DIV LUT constant;
  - the octave reload function (255 >> n);
  - the state enum {IDLE, PLAY};
  - the NOTE_MAX constant (=11).
- Optional sub-module tone_div_lut: purely combinational note -> divider lookup. Everything else stays in note_tone_gen.

Test Plan:
- Reset then note_valid with octave 5, note 0, rest=0:
  - note_ack pulses 1 cycle after the strobe;
  - speaker half-period 4096 clk (512*8), full period 8192;
  - active=1.
- Octave 5, note 11: half-period 2168 clk (271*8). Octave 0, note 0: half-period 131072 clk.
- While playing octave 5, note 0, strobe octave 4, note 0 mid half-period:
  - the current 4096-cycle half-period completes;
  - then note_ack pulses;
  - subsequent half-periods are 8192 cycles;
  - no short pulse in between.
- Assert rest 1000 cycles into a half-period:
  - speaker holds its level until the boundary, then goes to 0;
  - active drops on the same edge;
  - the state stays IDLE until a new strobe.
- Strobe note 13 or octave 6: note_ack pulses, active=0, speaker stays 0.
- Drop rst_n asynchronously mid-tone, between clk edges: speaker, active and counters go to 0 immediately. After release, speaker stays 0 for 10000 cycles with no strobe.
